// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon encryption controller.
package ascon_pack;

    // Controller states, one per phase of an Ascon encryption.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT_AD,
        ST_AD,
        ST_WAIT_PT,
        ST_PT,
        ST_FINAL,
        ST_END
    } state_t;

    // etat_up: what gets loaded into the upper state words.
    localparam logic [1:0] UP_NONE     = 2'b00;
    localparam logic [1:0] UP_DATA     = 2'b01;
    localparam logic [1:0] UP_KEY      = 2'b10;
    localparam logic [1:0] UP_DATA_KEY = 2'b11;

    // etat_down: what gets folded into the lower state words after a round.
    localparam logic [1:0] DOWN_NONE   = 2'b00;
    localparam logic [1:0] DOWN_KEY    = 2'b01;
    localparam logic [1:0] DOWN_LSB    = 2'b10;
    localparam logic [1:0] DOWN_BOTH   = 2'b11;

    // Round numbering: p12 runs 0..11, p6 runs 6..11.
    localparam logic [3:0] ROUND_P12_FIRST = 4'd0;
    localparam logic [3:0] ROUND_P6_FIRST  = 4'd6;
    localparam logic [3:0] ROUND_LAST      = 4'd11;

endpackage

// File: rtl/ascon_control.sv
// Ascon encryption controller: sequences the permutation datapath through
// initialisation, associated data, plaintext and finalisation.
module ascon_control
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [2:0] ad_count_i,
    input  logic [2:0] pt_count_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       select_o,
    output logic       enable_o,
    output logic [3:0] round_o,
    output logic [1:0] etat_up_o,
    output logic [1:0] etat_down_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       busy_o
);

    state_t     r_state;
    logic [3:0] r_round;
    logic [2:0] r_adCount;
    logic [2:0] r_ptCount;

    state_t     w_stateNext;
    logic [3:0] w_roundNext;
    logic [2:0] w_adNext;
    logic [2:0] w_ptNext;
    logic       w_start;

    // Start is masked by reset so the IDLE start decode cannot leak out while reset is held.
    assign w_start = start_i & resetb_i;

    // Every state except IDLE counts as busy.
    assign busy_o = (r_state != ST_IDLE);

    // State, round counter and block counters; reset aborts any message in flight.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state   <= ST_IDLE;
            r_round   <= 4'd0;
            r_adCount <= 3'd0;
            r_ptCount <= 3'd0;
        end else begin
            r_state   <= w_stateNext;
            r_round   <= w_roundNext;
            r_adCount <= w_adNext;
            r_ptCount <= w_ptNext;
        end
    end

    // Next-state and datapath control decode from state, counters and data_valid_i.
    always_comb begin
        w_stateNext    = r_state;
        w_roundNext    = r_round;
        w_adNext       = r_adCount;
        w_ptNext       = r_ptCount;
        select_o       = 1'b0;
        enable_o       = 1'b0;
        round_o        = r_round;
        etat_up_o      = UP_NONE;
        etat_down_o    = DOWN_NONE;
        data_ready_o   = 1'b0;
        cipher_valid_o = 1'b0;
        tag_valid_o    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                round_o = ROUND_P12_FIRST;
                if (w_start) begin
                    select_o    = 1'b1;
                    enable_o    = 1'b1;
                    w_stateNext = ST_INIT;
                    w_roundNext = ROUND_P12_FIRST + 4'd1;
                    w_adNext    = ad_count_i;
                    w_ptNext    = (pt_count_i == 3'd0) ? 3'd1 : pt_count_i;
                end
            end

            ST_INIT: begin
                enable_o = 1'b1;
                if (r_round == ROUND_LAST) begin
                    etat_down_o = (r_adCount == 3'd0) ? DOWN_BOTH : DOWN_KEY;
                    w_stateNext = (r_adCount == 3'd0) ? ST_WAIT_PT : ST_WAIT_AD;
                end else begin
                    w_roundNext = r_round + 4'd1;
                end
            end

            ST_WAIT_AD: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    enable_o    = 1'b1;
                    round_o     = ROUND_P6_FIRST;
                    etat_up_o   = UP_DATA;
                    w_stateNext = ST_AD;
                    w_roundNext = ROUND_P6_FIRST + 4'd1;
                    if (r_adCount != 3'd0) begin
                        w_adNext = r_adCount - 3'd1;
                    end
                end
            end

            ST_AD: begin
                enable_o = 1'b1;
                if (r_round == ROUND_LAST) begin
                    if (r_adCount == 3'd0) begin
                        etat_down_o = DOWN_LSB;
                        w_stateNext = ST_WAIT_PT;
                    end else begin
                        w_stateNext = ST_WAIT_AD;
                    end
                end else begin
                    w_roundNext = r_round + 4'd1;
                end
            end

            ST_WAIT_PT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    enable_o       = 1'b1;
                    cipher_valid_o = 1'b1;
                    if (r_ptCount <= 3'd1) begin
                        round_o     = ROUND_P12_FIRST;
                        etat_up_o   = UP_DATA_KEY;
                        w_stateNext = ST_FINAL;
                        w_roundNext = ROUND_P12_FIRST + 4'd1;
                    end else begin
                        round_o     = ROUND_P6_FIRST;
                        etat_up_o   = UP_DATA;
                        w_stateNext = ST_PT;
                        w_roundNext = ROUND_P6_FIRST + 4'd1;
                    end
                    if (r_ptCount != 3'd0) begin
                        w_ptNext = r_ptCount - 3'd1;
                    end
                end
            end

            ST_PT: begin
                enable_o = 1'b1;
                if (r_round == ROUND_LAST) begin
                    w_stateNext = ST_WAIT_PT;
                end else begin
                    w_roundNext = r_round + 4'd1;
                end
            end

            ST_FINAL: begin
                enable_o = 1'b1;
                if (r_round == ROUND_LAST) begin
                    etat_down_o = DOWN_KEY;
                    w_stateNext = ST_END;
                    w_roundNext = 4'd0;
                end else begin
                    w_roundNext = r_round + 4'd1;
                end
            end

            ST_END: begin
                tag_valid_o = 1'b1;
                w_stateNext = ST_IDLE;
                w_roundNext = 4'd0;
            end

            default: begin
                w_stateNext = ST_IDLE;
                w_roundNext = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_control.sv
// Directed testbench for ascon_control: per-cycle checkpoint tables for
// whole encryptions plus hand-written stall, late-start and reset sequences.
module tb_ascon_control;

    logic       clock_i;
    logic       resetb_i;
    logic       start_i;
    logic [2:0] ad_count_i;
    logic [2:0] pt_count_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic       select_o;
    logic       enable_o;
    logic [3:0] round_o;
    logic [1:0] etat_up_o;
    logic [1:0] etat_down_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic       busy_o;

    typedef struct packed {
        logic       sel;
        logic       en;
        logic [3:0] rnd;
        logic [1:0] up;
        logic [1:0] down;
        logic       rdy;
        logic       cv;
        logic       tag;
        logic       busy;
    } outVec_t;

    typedef struct {
        int      seq;
        int      cycle;
        outVec_t exp;
    } vec_t;

    vec_t    vecTable[$];
    outVec_t actual;
    int      nChecks = 0;
    int      nFails  = 0;
    int      tagCount;

    ascon_control dut (
        .clock_i        (clock_i),
        .resetb_i       (resetb_i),
        .start_i        (start_i),
        .ad_count_i     (ad_count_i),
        .pt_count_i     (pt_count_i),
        .data_valid_i   (data_valid_i),
        .data_ready_o   (data_ready_o),
        .select_o       (select_o),
        .enable_o       (enable_o),
        .round_o        (round_o),
        .etat_up_o      (etat_up_o),
        .etat_down_o    (etat_down_o),
        .cipher_valid_o (cipher_valid_o),
        .tag_valid_o    (tag_valid_o),
        .busy_o         (busy_o)
    );

    // 10 ns clock.
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Bundle all outputs so one comparison covers the whole control word.
    assign actual = '{sel: select_o, en: enable_o, rnd: round_o, up: etat_up_o,
                      down: etat_down_o, rdy: data_ready_o, cv: cipher_valid_o,
                      tag: tag_valid_o, busy: busy_o};

    function automatic outVec_t mk(input logic sel, input logic en, input logic [3:0] rnd,
                                   input logic [1:0] up, input logic [1:0] down,
                                   input logic rdy, input logic cv, input logic tag,
                                   input logic busy);
        mk = '{sel: sel, en: en, rnd: rnd, up: up, down: down, rdy: rdy, cv: cv,
               tag: tag, busy: busy};
    endfunction

    function automatic outVec_t rnd(input logic [3:0] r, input logic [1:0] down);
        rnd = mk(1'b0, 1'b1, r, 2'b00, down, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic addVec(input int seq, input int cycle, input outVec_t exp);
        vec_t v;
        v.seq   = seq;
        v.cycle = cycle;
        v.exp   = exp;
        vecTable.push_back(v);
    endtask

    task automatic checkOutput(input string name, input outVec_t act, input outVec_t exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got sel=%b en=%b rnd=%0d up=%b down=%b rdy=%b cv=%b tag=%b busy=%b, want sel=%b en=%b rnd=%0d up=%b down=%b rdy=%b cv=%b tag=%b busy=%b",
                     name, act.sel, act.en, act.rnd, act.up, act.down, act.rdy, act.cv, act.tag, act.busy,
                     exp.sel, exp.en, exp.rnd, exp.up, exp.down, exp.rdy, exp.cv, exp.tag, exp.busy);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Runs one encryption from IDLE, checking every table entry for this sequence.
    // Entered just after a rising edge; start_i is pulsed on cycle 0 and again on
    // restartAt when that is non-negative.
    task automatic applyStimulus(input int seq, input logic [2:0] ad, input logic [2:0] pt,
                                 input int nCycles, input int restartAt);
        ad_count_i   = ad;
        pt_count_i   = pt;
        data_valid_i = 1'b1;
        tagCount     = 0;
        for (int c = 0; c < nCycles; c++) begin
            start_i = (c == 0) || (c == restartAt);
            @(negedge clock_i);
            if (tag_valid_o) tagCount++;
            for (int i = 0; i < vecTable.size(); i++) begin
                if (vecTable[i].seq == seq && vecTable[i].cycle == c)
                    checkOutput($sformatf("seq%0d_cycle%0d", seq, c), actual, vecTable[i].exp);
            end
            @(posedge clock_i);
            #1;
        end
        start_i = 1'b0;
    endtask

    initial begin
        outVec_t zero;
        outVec_t waitIdle;
        zero     = '0;
        waitIdle = mk(1'b0, 1'b0, 4'd11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Sequence 1: ad=0, pt=1.
        addVec(1,  0, mk(1'b1, 1'b1, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        addVec(1,  1, rnd(4'd1, 2'b00));
        addVec(1,  5, rnd(4'd5, 2'b00));
        addVec(1, 10, rnd(4'd10, 2'b00));
        addVec(1, 11, rnd(4'd11, 2'b11));
        addVec(1, 12, mk(1'b0, 1'b1, 4'd0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1));
        addVec(1, 13, rnd(4'd1, 2'b00));
        addVec(1, 22, rnd(4'd10, 2'b00));
        addVec(1, 23, rnd(4'd11, 2'b01));
        addVec(1, 24, mk(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        addVec(1, 25, zero);

        // Sequence 2: ad=2, pt=2.
        addVec(2, 11, rnd(4'd11, 2'b01));
        addVec(2, 12, mk(1'b0, 1'b1, 4'd6, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1));
        addVec(2, 13, rnd(4'd7, 2'b00));
        addVec(2, 17, rnd(4'd11, 2'b00));
        addVec(2, 18, mk(1'b0, 1'b1, 4'd6, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1));
        addVec(2, 19, rnd(4'd7, 2'b00));
        addVec(2, 23, rnd(4'd11, 2'b10));
        addVec(2, 24, mk(1'b0, 1'b1, 4'd6, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1));
        addVec(2, 25, rnd(4'd7, 2'b00));
        addVec(2, 29, rnd(4'd11, 2'b00));
        addVec(2, 30, mk(1'b0, 1'b1, 4'd0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1));
        addVec(2, 31, rnd(4'd1, 2'b00));
        addVec(2, 41, rnd(4'd11, 2'b01));
        addVec(2, 42, mk(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        addVec(2, 43, zero);

        // Sequence 3: start pulsed again during FINAL round 3 must change nothing.
        addVec(3, 15, rnd(4'd3, 2'b00));
        addVec(3, 24, mk(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        addVec(3, 25, zero);
        addVec(3, 30, zero);

        // Reset held with start and valid high: everything must read zero.
        resetb_i     = 1'b0;
        start_i      = 1'b1;
        data_valid_i = 1'b1;
        ad_count_i   = 3'd3;
        pt_count_i   = 3'd3;
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        checkOutput("reset_held", actual, zero);
        start_i      = 1'b0;
        @(posedge clock_i);
        #1;
        resetb_i = 1'b1;
        @(posedge clock_i);
        #1;

        $display("[TB] ad=0 pt=1 basic encryption");
        applyStimulus(1, 3'd0, 3'd1, 26, -1);
        checkInt("seq1_tag_pulses", tagCount, 1);

        $display("[TB] ad=2 pt=2 encryption");
        applyStimulus(2, 3'd2, 3'd2, 44, -1);
        checkInt("seq2_tag_pulses", tagCount, 1);

        $display("[TB] start during FINAL");
        applyStimulus(3, 3'd0, 3'd1, 40, 15);
        checkInt("seq3_tag_pulses", tagCount, 1);

        // Stall in WAIT_PT for five cycles, then transfer on the first valid cycle.
        $display("[TB] data_valid stall in WAIT_PT");
        ad_count_i   = 3'd0;
        pt_count_i   = 3'd0;
        data_valid_i = 1'b0;
        start_i      = 1'b1;
        for (int c = 0; c < 30; c++) begin
            data_valid_i = (c >= 17);
            @(negedge clock_i);
            if (c == 11) checkOutput("stall_init_last", actual, rnd(4'd11, 2'b11));
            if (c >= 12 && c <= 16) checkOutput($sformatf("stall_wait_c%0d", c), actual, waitIdle);
            if (c == 17) checkOutput("stall_transfer", actual,
                                     mk(1'b0, 1'b1, 4'd0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1));
            if (c == 18) checkOutput("stall_final_r1", actual, rnd(4'd1, 2'b00));
            if (c == 29) checkOutput("stall_end", actual, mk(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
            @(posedge clock_i);
            #1;
            start_i = 1'b0;
        end
        @(negedge clock_i);
        checkOutput("stall_idle", actual, zero);
        @(posedge clock_i);
        #1;

        // Asynchronous reset during INIT round 5, then a complete fresh encryption.
        $display("[TB] reset during INIT");
        ad_count_i   = 3'd0;
        pt_count_i   = 3'd1;
        data_valid_i = 1'b1;
        start_i      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock_i);
            #1;
            start_i = 1'b0;
        end
        @(negedge clock_i);
        checkOutput("pre_reset_r5", actual, rnd(4'd5, 2'b00));
        #2;
        resetb_i = 1'b0;
        #1;
        checkOutput("async_reset", actual, zero);
        @(posedge clock_i);
        #1;
        resetb_i = 1'b1;
        @(posedge clock_i);
        #1;
        applyStimulus(1, 3'd0, 3'd1, 26, -1);
        checkInt("after_reset_tag_pulses", tagCount, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
